rr_arbiter_4: RTL

- Round-robin arbiter that shares one resource among 4 requesters.
- Grants are one-hot, and each grant carries its 2-bit index.
- Intended to select one of the four consumers driven by the 2-to-4 decode path, e.g. a shared bus or memory port.
- Grant tenure is bounded by a hold timer, so one requester cannot starve the others.

---
 rtl/rr_arbiter_4.sv | 97 +++++++++
 1 files changed

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with a bounded grant tenure.
// Registered one-hot grant, encoded index and a timeout preempt pulse.
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       preempt
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state, state_nx;
    logic [1:0]       ptr, ptr_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [3:0]       gnt_nx;
    logic [1:0]       idx_nx;
    logic             pre_nx;
    logic [1:0]       win;
    logic             win_ok;

    // Scan from the farthest offset down so the nearest request to ptr wins.
    always_comb begin
        win    = 2'd0;
        win_ok = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (req[ptr + 2'(i)]) begin
                win    = ptr + 2'(i);
                win_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        gnt_nx   = gnt;
        idx_nx   = gnt_idx;
        pre_nx   = 1'b0;
        unique case (state)
            IDLE: begin
                if (win_ok) begin
                    gnt_nx   = 4'b0001 << win;
                    idx_nx   = win;
                    cnt_nx   = '0;
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                if (!req[gnt_idx] || cnt == CNT_LAST) begin
                    // A voluntary drop wins over a coincident timeout.
                    pre_nx   = req[gnt_idx];
                    gnt_nx   = '0;
                    idx_nx   = 2'd0;
                    cnt_nx   = '0;
                    ptr_nx   = gnt_idx + 2'd1;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 2'd0;
            cnt     <= '0;
            gnt     <= '0;
            gnt_idx <= 2'd0;
            preempt <= 1'b0;
        end else begin
            state   <= state_nx;
            ptr     <= ptr_nx;
            cnt     <= cnt_nx;
            gnt     <= gnt_nx;
            gnt_idx <= idx_nx;
            preempt <= pre_nx;
        end
    end

    assign gnt_valid = |gnt;

endmodule
